// File: rtl/aes_pkg.sv
// ============================================================================
//  Module   : aes_pkg
//  Purpose  : Shared types and constants for the AES round controller.
//             Holds the controller state enumeration, the AddRoundKey
//             source encodings, the round counts of the three AES key sizes
//             and the round index width.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    // Round index width; 4 bits covers 0..14, the largest legal NR.
    localparam int unsigned ROUND_W = 4;

    // Number of rounds per key size.
    localparam int unsigned NR_AES128 = 10;
    localparam int unsigned NR_AES192 = 12;
    localparam int unsigned NR_AES256 = 14;

    // AddRoundKey input source select. Code 3 is never driven.
    localparam logic [1:0] ARK_SRC_PLAIN = 2'd0;  // initial whitening key
    localparam logic [1:0] ARK_SRC_MIX   = 2'd1;  // rounds 1..NR-1
    localparam logic [1:0] ARK_SRC_SHIFT = 2'd2;  // final round skips MixColumns

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SUB   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_MIX   = 3'd3,
        ST_ARK   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage : aes_pkg

`default_nettype wire

// File: rtl/aes_round_ctrl.sv
// ============================================================================
//  Module   : aes_round_ctrl
//  Purpose  : Sequences one AES block encryption through the SubBytes,
//             ShiftRows, MixColumns and AddRoundKey stage registers. Emits
//             one-cycle stage enables, the round index for the key schedule
//             and the AddRoundKey source select. Stalls in AddRoundKey while
//             the key schedule is not ready; supports synchronous abort.
//  Ports    : i_clock        system clock (rising edge)
//             i_reset_n      asynchronous active-low reset
//             i_start        start encryption of the presented block
//             i_abort        synchronous abort of the running operation
//             i_key_ready    round key for o_round is valid this cycle
//             o_busy         operation in progress (not IDLE / DONE)
//             o_done         one-cycle pulse, ciphertext valid
//             o_round        current round index 0..NR
//             o_sub_active   SubBytes enable
//             o_shift_active ShiftRows enable
//             o_mix_active   MixColumns enable
//             o_ark_active   AddRoundKey enable
//             o_ark_src      AddRoundKey source (plain / mix / shift)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = NR_AES128   // 10, 12 or 14
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_key_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic [ROUND_W-1:0] o_round,
    output logic               o_sub_active,
    output logic               o_shift_active,
    output logic               o_mix_active,
    output logic               o_ark_active,
    output logic [1:0]         o_ark_src
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NR);

    state_e             state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;

    // ------------------------------------------------------------------
    // State and round registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and round counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        round_d = round_q;

        // Abort wins over start, stall and the DONE restart alike.
        if (i_abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            round_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_d = ST_ARK;
                        round_d = '0;
                    end
                end
                ST_ARK: begin
                    // Without a valid key, hold state and round.
                    if (i_key_ready) begin
                        if (round_q == LAST_ROUND) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_SUB;
                            round_d = round_q + ROUND_W'(1);
                        end
                    end
                end
                ST_SUB: begin
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    // The last round has no MixColumns.
                    state_d = (round_q == LAST_ROUND) ? ST_ARK : ST_MIX;
                end
                ST_MIX: begin
                    state_d = ST_ARK;
                end
                ST_DONE: begin
                    // Round stays at NR for the DONE cycle only.
                    state_d = i_start ? ST_ARK : ST_IDLE;
                    round_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    round_d = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode (o_ark_active additionally gated by key ready)
    // ------------------------------------------------------------------
    always_comb begin
        o_busy         = 1'b0;
        o_done         = 1'b0;
        o_sub_active   = 1'b0;
        o_shift_active = 1'b0;
        o_mix_active   = 1'b0;
        o_ark_active   = 1'b0;
        o_ark_src      = ARK_SRC_PLAIN;

        case (state_q)
            ST_SUB: begin
                o_busy       = 1'b1;
                o_sub_active = 1'b1;
            end
            ST_SHIFT: begin
                o_busy         = 1'b1;
                o_shift_active = 1'b1;
            end
            ST_MIX: begin
                o_busy       = 1'b1;
                o_mix_active = 1'b1;
            end
            ST_ARK: begin
                o_busy       = 1'b1;
                o_ark_active = i_key_ready;
                if (round_q == '0) begin
                    o_ark_src = ARK_SRC_PLAIN;
                end else if (round_q == LAST_ROUND) begin
                    o_ark_src = ARK_SRC_SHIFT;
                end else begin
                    o_ark_src = ARK_SRC_MIX;
                end
            end
            ST_DONE: begin
                o_done = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    assign o_round = round_q;

endmodule : aes_round_ctrl

`default_nettype wire

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequences one AES block encryption through the SubBytes, ShiftRows, MixColumns and AddRoundKey stage registers.
- Issues one-cycle stage-enable strobes, the current round index for the key schedule, and the AddRoundKey input-source select.
- Sits between the top-level start/done handshake and the round datapath.
- Stalls on the key-schedule ready signal, and supports abort.

Parameters:
- NR, 10, number of AES rounds; legal values 10, 12, 14 (AES-128/192/256).

Ports:
- i_clock  input  1  system clock; controller state updates on rising edge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_start  input  1  request to encrypt the block currently presented to the datapath.
- i_abort  input  1  synchronous abort of the operation in progress.
- i_key_ready  input  1  round key words for o_round are valid this cycle.
- o_busy  output  1  operation in progress (any state other than IDLE or DONE).
- o_done  output  1  one-cycle pulse; ciphertext is valid in the AddRoundKey output register.
- o_round  output  [0:3]  current round index, 0..NR; drives key-word selection.
- o_sub_active  output  1  SubBytes stage enable.
- o_shift_active  output  1  ShiftRows stage enable.
- o_mix_active  output  1  MixColumns stage enable.
- o_ark_active  output  1  AddRoundKey stage enable.
- o_ark_src  output  [0:1]  AddRoundKey data source: 0 = plaintext, 1 = MixColumns output, 2 = ShiftRows output; 3 is never driven.

Behaviour:
- Reset: on i_reset_n low, immediately go to IDLE with round = 0. All outputs are 0 while in reset, including o_ark_src = 0.
- Output timing: all outputs are Moore-decoded from registered state and round. They change only after the rising edge, so they are stable when the stage registers sample on the falling edge of the same cycle.
- Exactly one *_active strobe is high in any cycle, or none.
- States: IDLE, SUB, SHIFT, MIX, ARK, DONE.
- IDLE: no strobes.
  - i_start = 1 and i_abort = 0 → ARK, round = 0.
- ARK:
  - o_ark_src = 0 if round = 0; 2 if round = NR; otherwise 1.
  - o_ark_active = i_key_ready.
  - If i_key_ready = 0: hold state and round (stall), no strobe.
  - Else if round = NR → DONE.
  - Else → SUB with round + 1.
- SUB: o_sub_active = 1; → SHIFT.
- SHIFT: o_shift_active = 1.
  - → ARK if round = NR; else → MIX.
- MIX: o_mix_active = 1; → ARK.
- DONE: o_done = 1 and o_busy = 0; round stays NR.
  - i_start = 1 → ARK, round = 0 (back-to-back operation).
  - Else → IDLE with round = 0.
- Total strobe cycles per block = 1 + 4(NR−1) + 3 = 4·NR.
- Latency with no stalls:
  - The state enters DONE at the 4·NR-th rising edge after the edge that sampled i_start; o_done is high for the following cycle.
  - NR = 10: 40 edges.
  - Each cycle with i_key_ready low while in ARK adds exactly one cycle.
- i_start while busy: ignored.
- i_abort:
  - In any state except IDLE: next edge → IDLE, round = 0, no o_done.
  - Takes priority over i_start, over stall, and over the DONE back-to-back restart.
- Reset mid-operation: strobes drop to 0 asynchronously. No partial o_done is issued.
- Round counter: 4-bit. Never exceeds NR and never wraps.

Decomposition:
- Shared package aes_pkg holds:
  - state enumeration;
  - ARK_SRC_PLAIN = 0, ARK_SRC_MIX = 1, ARK_SRC_SHIFT = 2;
  - NR constants for AES-128/192/256;
  - round index width = 4.
- No sub-module: FSM and round counter are a single always block plus output decode.

Test Plan:
- Reset asserted mid-round (state MIX, round 5) → all strobes, o_busy and o_done are 0 immediately. After release, i_start gives o_round = 0 and o_ark_src = 0 on the first strobe.
- NR = 10, i_key_ready tied 1, i_start pulse → strobe sequence:
  - ARK(src 0, round 0);
  - 9× (SUB, SHIFT, MIX, ARK src 1, rounds 1..9);
  - round 10: SUB, SHIFT, ARK src 2;
  - o_done high exactly 40 edges after start; 40 strobes total.
- i_key_ready held low for 3 cycles in round 4 ARK → no strobe during the stall, o_round stays 4, o_done is delayed by exactly 3 cycles to edge 43.
- i_abort asserted in round 7 SHIFT with i_start also high → IDLE next edge, round = 0, no o_done. A later i_start runs a full 40-cycle operation.
- i_start held high continuously → o_done pulses every 41 cycles. In DONE, the restart goes directly to ARK round 0; i_start pulses mid-operation are ignored.
- NR = 14 → 56 strobe cycles; final ARK uses src 2 with o_round = 14.
